// File: rtl/uart_csr_bank.sv
// ---------------------------------------------------------------------------
// uart_csr_bank
//   Configuration and status register bank for NUM_CH UART channels on the
//   bus2ip bus. Each channel has a baud divisor, frame control, self-timed
//   RX/TX FIFO reset pulses and a live FIFO status view. When the optional
//   interrupt feature is built in, each channel also has sticky rising-edge
//   event flags, per-event enables and one level interrupt.
//
//   Optional feature macro: UART_CSR_IRQ_EN
//     defined   : ISTS/IEN/IPEND registers, edge capture and irq_o are built
//     undefined : offsets 0x4-0x6 read 0 and ignore writes, irq_o is 0
//
// Ports
//   bus2ip_clk      single clock
//   bus2ip_rst_n    synchronous active-low reset
//   bus2ip_addr_i   [15:12] bank, [11:4] channel, [3:0] register offset
//   bus2ip_data_i   write data
//   bus2ip_rd_ce_i  read strobe
//   bus2ip_wr_ce_i  write strobe, one write per asserted cycle
//   ip2bus_data_o   combinational read data (0 when not a hitting read)
//   fifo_status_i   9 status bits per channel
//   baud_config_o   16-bit divisor per channel
//   frame_ctrl_o    {parity_odd,parity_en,msb_first,start_polarity} per ch
//   rx_fifo_rst_o   RX FIFO reset pulse per channel
//   tx_fifo_rst_o   TX FIFO reset pulse per channel
//   irq_o           registered interrupt level per channel
// ---------------------------------------------------------------------------
module uart_csr_bank #(
  parameter logic [3:0]  BASEADDR      = 4'h0,
  parameter int          NUM_CH        = 2,
  parameter logic [15:0] BAUD_RST      = 16'd68,
  parameter int          RST_PULSE_LEN = 2
) (
  input  logic                  bus2ip_clk,
  input  logic                  bus2ip_rst_n,
  input  logic [15:0]           bus2ip_addr_i,
  input  logic [15:0]           bus2ip_data_i,
  input  logic                  bus2ip_rd_ce_i,
  input  logic                  bus2ip_wr_ce_i,
  output logic [15:0]           ip2bus_data_o,
  input  logic [NUM_CH*9-1:0]   fifo_status_i,
  output logic [NUM_CH*16-1:0]  baud_config_o,
  output logic [NUM_CH*4-1:0]   frame_ctrl_o,
  output logic [NUM_CH-1:0]     rx_fifo_rst_o,
  output logic [NUM_CH-1:0]     tx_fifo_rst_o,
  output logic [NUM_CH-1:0]     irq_o
);

  localparam logic [3:0] OFS_BAUD  = 4'h0;
  localparam logic [3:0] OFS_CTRL  = 4'h1;
  localparam logic [3:0] OFS_FRST  = 4'h2;
  localparam logic [3:0] OFS_STAT  = 4'h3;
  localparam logic [3:0] OFS_IEN   = 4'h4;
  localparam logic [3:0] OFS_ISTS  = 4'h5;
  localparam logic [3:0] OFS_IPEND = 4'h6;

  localparam logic [8:0] NUM_CH_L  = 9'(NUM_CH);
  localparam logic [3:0] PULSE_LEN = 4'(RST_PULSE_LEN);

  logic               bank_hit_s;
  logic [3:0]         ofs_s;
  logic [NUM_CH-1:0]  ch_sel_s;
  logic [15:0]        ch_rd_s [NUM_CH];
  logic [15:0]        rd_data_s;

  assign ofs_s      = bus2ip_addr_i[3:0];
  // Channel field is compared at full 8-bit width so aliased indices miss.
  assign bank_hit_s = (bus2ip_addr_i[15:12] == BASEADDR) &&
                      ({1'b0, bus2ip_addr_i[11:4]} < NUM_CH_L);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic        wr_s;
    logic [8:0]  st_s;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic        rx_rst_q, tx_rst_q;
    logic [8:0]  ien_rd_s, ists_rd_s;
    logic [15:0] rd_s;

    assign ch_sel_s[gi] = bank_hit_s && (bus2ip_addr_i[11:4] == 8'(gi));
    assign wr_s         = bus2ip_wr_ce_i && ch_sel_s[gi];
    assign st_s         = fifo_status_i[9*gi +: 9];

    // Next state for configuration registers and FIFO reset pulse counters.
    always_comb begin
      baud_d   = baud_q;
      ctrl_d   = ctrl_q;
      rx_cnt_d = (rx_cnt_q != 4'd0) ? (rx_cnt_q - 4'd1) : 4'd0;
      tx_cnt_d = (tx_cnt_q != 4'd0) ? (tx_cnt_q - 4'd1) : 4'd0;
      if (wr_s) begin
        case (ofs_s)
          OFS_BAUD: baud_d = bus2ip_data_i;
          OFS_CTRL: ctrl_d = bus2ip_data_i[3:0];
          OFS_FRST: begin
            // A set bit (re)loads the counter, so a rewrite extends the pulse.
            rx_cnt_d = bus2ip_data_i[0] ? PULSE_LEN : rx_cnt_d;
            tx_cnt_d = bus2ip_data_i[1] ? PULSE_LEN : tx_cnt_d;
          end
          default: begin
            baud_d = baud_q;
          end
        endcase
      end else begin
        baud_d = baud_q;
      end
    end

    // Configuration registers, pulse counters and registered pulse outputs.
    always_ff @(posedge bus2ip_clk) begin
      if (!bus2ip_rst_n) begin
        baud_q   <= BAUD_RST;
        ctrl_q   <= 4'h0;
        rx_cnt_q <= 4'd0;
        tx_cnt_q <= 4'd0;
        rx_rst_q <= 1'b0;
        tx_rst_q <= 1'b0;
      end else begin
        baud_q   <= baud_d;
        ctrl_q   <= ctrl_d;
        rx_cnt_q <= rx_cnt_d;
        tx_cnt_q <= tx_cnt_d;
        // Output lags the counter by one edge: high exactly PULSE_LEN cycles.
        rx_rst_q <= (rx_cnt_q != 4'd0);
        tx_rst_q <= (tx_cnt_q != 4'd0);
      end
    end

`ifdef UART_CSR_IRQ_EN
    logic [8:0] stat_q;
    logic [8:0] ien_q, ien_d;
    logic [8:0] ists_q, ists_d;
    logic [8:0] w1c_s, rise_s;
    logic       irq_q;

    assign rise_s = st_s & ~stat_q;

    // Interrupt enable / sticky status next state; a new rise beats a W1C.
    always_comb begin
      ien_d = ien_q;
      w1c_s = 9'h000;
      if (wr_s) begin
        case (ofs_s)
          OFS_IEN:  ien_d = bus2ip_data_i[8:0];
          OFS_ISTS: w1c_s = bus2ip_data_i[8:0];
          default:  w1c_s = 9'h000;
        endcase
      end else begin
        w1c_s = 9'h000;
      end
      ists_d = (ists_q & ~w1c_s) | rise_s;
    end

    // Edge-detect history, interrupt registers and registered irq level.
    always_ff @(posedge bus2ip_clk) begin
      if (!bus2ip_rst_n) begin
        stat_q <= 9'h000;
        ien_q  <= 9'h000;
        ists_q <= 9'h000;
        irq_q  <= 1'b0;
      end else begin
        stat_q <= st_s;
        ien_q  <= ien_d;
        ists_q <= ists_d;
        irq_q  <= |(ists_d & ien_d);
      end
    end

    assign ien_rd_s  = ien_q;
    assign ists_rd_s = ists_q;
    assign irq_o[gi] = irq_q;
`else
    assign ien_rd_s  = 9'h000;
    assign ists_rd_s = 9'h000;
    assign irq_o[gi] = 1'b0;
`endif

    // Per-channel read mux by register offset.
    always_comb begin
      case (ofs_s)
        OFS_BAUD:  rd_s = baud_q;
        OFS_CTRL:  rd_s = {12'h000, ctrl_q};
        OFS_STAT:  rd_s = {7'h00, st_s};
        OFS_IEN:   rd_s = {7'h00, ien_rd_s};
        OFS_ISTS:  rd_s = {7'h00, ists_rd_s};
        OFS_IPEND: rd_s = {7'h00, ists_rd_s & ien_rd_s};
        default:   rd_s = 16'h0000;
      endcase
    end

    assign ch_rd_s[gi]                = rd_s;
    assign baud_config_o[16*gi +: 16] = baud_q;
    assign frame_ctrl_o[4*gi +: 4]    = ctrl_q;
    assign rx_fifo_rst_o[gi]          = rx_rst_q;
    assign tx_fifo_rst_o[gi]          = tx_rst_q;
  end

  // Combine channel read data; at most one channel is selected.
  always_comb begin
    rd_data_s = 16'h0000;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_data_s = rd_data_s | (ch_rd_s[c] & {16{bus2ip_rd_ce_i & ch_sel_s[c]}});
    end
  end

  assign ip2bus_data_o = rd_data_s;

endmodule

// File: tb/tb_uart_csr_bank.sv
module tb_uart_csr_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rd_ce;
  logic        wr_ce;
  logic [15:0] rdata;
  logic [17:0] fifo_status;
  logic [31:0] baud_config;
  logic [7:0]  frame_ctrl;
  logic [1:0]  rx_rst;
  logic [1:0]  tx_rst;
  logic [1:0]  irq;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_csr_bank #(
    .BASEADDR(4'h0), .NUM_CH(2), .BAUD_RST(16'd68), .RST_PULSE_LEN(2)
  ) dut (
    .bus2ip_clk     (clk),
    .bus2ip_rst_n   (rst_n),
    .bus2ip_addr_i  (addr),
    .bus2ip_data_i  (wdata),
    .bus2ip_rd_ce_i (rd_ce),
    .bus2ip_wr_ce_i (wr_ce),
    .ip2bus_data_o  (rdata),
    .fifo_status_i  (fifo_status),
    .baud_config_o  (baud_config),
    .frame_ctrl_o   (frame_ctrl),
    .rx_fifo_rst_o  (rx_rst),
    .tx_fifo_rst_o  (tx_rst),
    .irq_o          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    wr_ce = 1'b1;
    tick();
    wr_ce = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    @(negedge clk);
    addr  = a;
    rd_ce = 1'b1;
    #1;
    chk(tag, {16'h0, rdata}, {16'h0, exp});
    rd_ce = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; addr = 16'h0; wdata = 16'h0; rd_ce = 1'b0; wr_ce = 1'b0;
    fifo_status = 18'h0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: reset state
    rd_chk("rst_baud_ch0", 16'h0000, 16'd68);
    rd_chk("rst_baud_ch1", 16'h0010, 16'd68);
    rd_chk("rst_ctrl_ch0", 16'h0001, 16'h0);
    rd_chk("rst_ctrl_ch1", 16'h0011, 16'h0);
    rd_chk("rst_ien_ch0",  16'h0004, 16'h0);
    rd_chk("rst_ists_ch1", 16'h0015, 16'h0);
    chk("rst_baud_out", baud_config, {16'd68, 16'd68});
    chk("rst_frame_out", {24'h0, frame_ctrl}, 32'h0);
    chk("rst_irq", {30'h0, irq}, 32'h0);
    chk("rst_rx_rst", {30'h0, rx_rst}, 32'h0);
    chk("rst_tx_rst", {30'h0, tx_rst}, 32'h0);

    // 2: configuration writes on ch1, ch0 untouched
    bus_write(16'h0010, 16'h0036);
    bus_write(16'h0011, 16'hFFFA);
    chk("ch1_baud_out", {16'h0, baud_config[31:16]}, 32'h0036);
    chk("ch0_baud_out", {16'h0, baud_config[15:0]}, 32'd68);
    chk("frame_out", {24'h0, frame_ctrl}, 32'h000000A0);
    rd_chk("ch1_baud_rd", 16'h0010, 16'h0036);
    rd_chk("ch1_ctrl_rd", 16'h0011, 16'h000A);
    rd_chk("ch0_ctrl_rd", 16'h0001, 16'h0000);
    fifo_status = 18'h2A5F3;
    rd_chk("stat_ch0", 16'h0003, 16'h01F3);
    rd_chk("stat_ch1", 16'h0013, 16'h0152);
    rd_chk("no_rd_ce", 16'h0010, 16'h0036);
    @(negedge clk);
    addr = 16'h0010;
    #1;
    chk("rd_ce_low", {16'h0, rdata}, 32'h0);
    fifo_status = 18'h0;
    tick(); tick();
`ifdef UART_CSR_IRQ_EN
    // clear any events captured from the status pattern above
    bus_write(16'h0005, 16'h01FF);
    bus_write(16'h0015, 16'h01FF);
`endif

    // 3: FIFO reset pulses
    bus_write(16'h0002, 16'h0001);
    chk("rx_pulse_n", {30'h0, rx_rst}, 32'h0);
    tick(); chk("rx_pulse_n1", {30'h0, rx_rst}, 32'h1);
    tick(); chk("rx_pulse_n2", {30'h0, rx_rst}, 32'h1);
    tick(); chk("rx_pulse_n3", {30'h0, rx_rst}, 32'h0);
    bus_write(16'h0002, 16'h0001);
    chk("ext_n", {30'h0, rx_rst}, 32'h0);
    bus_write(16'h0002, 16'h0001);
    chk("ext_n1", {30'h0, rx_rst}, 32'h1);
    tick(); chk("ext_n2", {30'h0, rx_rst}, 32'h1);
    tick(); chk("ext_n3", {30'h0, rx_rst}, 32'h1);
    tick(); chk("ext_n4", {30'h0, rx_rst}, 32'h0);
    bus_write(16'h0012, 16'h0002);
    chk("tx1_n", {30'h0, tx_rst}, 32'h0);
    tick();
    chk("tx1_n1", {30'h0, tx_rst}, 32'h2);
    chk("tx1_rx_quiet", {30'h0, rx_rst}, 32'h0);
    tick(); chk("tx1_n2", {30'h0, tx_rst}, 32'h2);
    tick(); chk("tx1_n3", {30'h0, tx_rst}, 32'h0);
    bus_write(16'h0002, 16'h0000);
    tick(); chk("frst_clear_bits", {30'h0, rx_rst}, 32'h0);
    rd_chk("frst_reads_0", 16'h0002, 16'h0000);

`ifdef UART_CSR_IRQ_EN
    // 4: event capture and interrupt
    bus_write(16'h0004, 16'h0100);
    rd_chk("ien_rd", 16'h0004, 16'h0100);
    fifo_status = 18'h00100;
    chk("irq_before", {30'h0, irq}, 32'h0);
    tick();
    chk("irq_set", {30'h0, irq}, 32'h1);
    rd_chk("ists_set", 16'h0005, 16'h0100);
    rd_chk("ipend_set", 16'h0006, 16'h0100);
    rd_chk("ists_ch1_quiet", 16'h0015, 16'h0000);
    bus_write(16'h0005, 16'h0100);
    chk("irq_w1c", {30'h0, irq}, 32'h0);
    rd_chk("ists_w1c", 16'h0005, 16'h0000);
    fifo_status = 18'h00101;
    tick();
    chk("irq_masked", {30'h0, irq}, 32'h0);
    rd_chk("ists_masked", 16'h0005, 16'h0001);
    rd_chk("ipend_masked", 16'h0006, 16'h0000);
    fifo_status = 18'h00100;
    bus_write(16'h0005, 16'h0001);

    // 5: set wins over W1C in the same cycle
    fifo_status = 18'h00000;
    tick();
    fifo_status = 18'h00100;
    tick();
    chk("irq_rerise", {30'h0, irq}, 32'h1);
    fifo_status = 18'h00000;
    tick();
    fifo_status = 18'h00100;
    bus_write(16'h0005, 16'h0100);
    chk("irq_set_wins", {30'h0, irq}, 32'h1);
    rd_chk("ists_set_wins", 16'h0005, 16'h0100);
    bus_write(16'h0005, 16'h0100);
    chk("irq_final_clr", {30'h0, irq}, 32'h0);
`else
    // 4/5: interrupt feature absent
    bus_write(16'h0004, 16'hFFFF);
    rd_chk("ien_absent", 16'h0004, 16'h0000);
    fifo_status = 18'h3FFFF;
    tick(); tick();
    chk("irq_absent", {30'h0, irq}, 32'h0);
    rd_chk("ists_absent", 16'h0005, 16'h0000);
    rd_chk("ipend_absent", 16'h0006, 16'h0000);
    fifo_status = 18'h0;
`endif

    // 6: address misses
    bus_write(16'h0020, 16'h1234);
    bus_write(16'h0100, 16'h4321);
    bus_write(16'h1000, 16'h5555);
    bus_write(16'h1011, 16'h0005);
    bus_write(16'h0007, 16'hFFFF);
    chk("miss_baud_out", baud_config, {16'h0036, 16'd68});
    chk("miss_frame_out", {24'h0, frame_ctrl}, 32'h000000A0);
    rd_chk("miss_ch2", 16'h0020, 16'h0000);
    rd_chk("miss_bank1", 16'h1000, 16'h0000);
    rd_chk("unused_ofs", 16'h0007, 16'h0000);
    rd_chk("still_ch0", 16'h0000, 16'd68);

    // reset during a pulse truncates it and restores defaults
    bus_write(16'h0002, 16'h0001);
    tick();
    chk("pre_rst_pulse", {30'h0, rx_rst}, 32'h1);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_pulse", {30'h0, rx_rst}, 32'h0);
    chk("rst_baud_again", baud_config, {16'd68, 16'd68});
    chk("rst_frame_again", {24'h0, frame_ctrl}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_pulse", {30'h0, rx_rst}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
